mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Consumes the execute stage's load/store controls
//  (re/we, address, load mask, byte enables, pre-shifted write data) and runs a req/gnt/rvalid data-bus handshake.
//  Aligns and extends load data, then forwards the load or ALU result toward writeback and the bypass network.
//  Stalls the pipe while a bus access is outstanding. Raises misaligned/timeout exceptions.
// PARAMETERS
//  XLEN        32   datapath width
//  TIMEOUT_CYC 255  max cycles from request to gnt/rvalid before bus-error exception (8-bit counter)
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      asynchronous active-low reset
//  pipe_flush      in   1      kill instruction in this stage
//  mem_valid       in   1      instruction present in stage
//  mem_re/mem_we   in   1/1    load / store request (already gated by ex_ok)
//  mem_ls_addr     in   XLEN   effective address
//  mem_l_mask      in   5      [3:0] 0001 byte, 0011 half, 1111 word; [4] 1 = sign-extend
//  mem_byte_we     in   4      store byte enables
//  mem_wdata       in   XLEN   pre-shifted store data
//  mem_alu_res     in   XLEN   non-load result
//  mem_req_rf_i    in   1      rd write request
//  mem_rf_waddr_i  in   5      rd address
//  dbus_req        out  1      bus request, held until dbus_gnt
//  dbus_we         out  1      1 = write
//  dbus_addr       out  XLEN   word-aligned address ({addr[31:2],2'b00})
//  dbus_be         out  4      byte enables (loads: derived from mask and addr[1:0])
//  dbus_wdata      out  XLEN   write data
//  dbus_gnt        in   1      request accepted
//  dbus_rvalid     in   1      read data valid (loads only)
//  dbus_rdata      in   XLEN   read data
//  mem_stall       out  1      freeze ex/mem and earlier stages
//  mem_req_rf_o    out  1      rd write enable to WB
//  mem_rf_waddr_o  out  5      rd address
//  mem_wb_data     out  XLEN   load data or mem_alu_res
//  mem_fw_valid    out  1      mem_wb_data valid for bypass this cycle
//  mem_exp_flag    out  1      exception raised by this stage
//  mem_exp_cause   out  4      4 ld-misaligned, 6 st-misaligned, 5 ld-fault, 7 st-fault (timeout)
// BEHAVIOUR
//  Reset: state IDLE; dbus_req/we/be/wdata/addr, mem_stall, mem_req_rf_o, mem_fw_valid, mem_exp_flag all 0;
//   load_data_q 0; timeout counter 0.
//  Misalign: half with addr[0]=1, or word with addr[1:0]!=0 -> no bus request, mem_exp_flag=1 combinationally,
//   mem_req_rf_o=0, no stall.
//  FSM: IDLE -(valid & (re|we) & aligned & ~flush)-> REQ: dbus_req=1, stall=1.
//   REQ -gnt & we-> DONE. REQ -gnt & re-> WAIT_R (stall=1).
//   WAIT_R -rvalid-> DONE; aligned/extended rdata registered into load_data_q.
//   DONE: one cycle, stall=0, mem_wb_data=load_data_q (loads), mem_fw_valid=1; the pipe advances -> IDLE.
//   Zero-latency gnt: REQ still takes one cycle; a load therefore needs >=3 cycles (REQ, WAIT_R, DONE).
//  Non-memory instructions: pass-through, no stall; mem_fw_valid=mem_valid&mem_req_rf_i.
//  Load align: byte = rdata >> (8*addr[1:0]), half = rdata >> (16*addr[1]); zero/sign-extend per mask[4].
//  Flush: in REQ -> drop req, IDLE. In WAIT_R -> DRAIN: await rvalid, discard data, no RF write;
//   a new mem op arriving in DRAIN sees stall=1 until DRAIN exits to IDLE.
//   Flush in DONE: no RF write, -> IDLE.
//  Timeout: counter clears on entering REQ/WAIT_R and increments each cycle there;
//   at TIMEOUT_CYC -> DONE with mem_exp_flag=1, cause 5/7, no RF write, dbus_req dropped.
//   DRAIN timeout -> IDLE silently.
//  Exceptions and flush always force mem_req_rf_o=0. Stores never wait for rvalid; a spurious rvalid is ignored.
//  Reset mid-access: async return to IDLE; the bus slave is reset on the same rst_n.
// STRUCTURE
//  defines.v: `XLEN, `RF_ADDR_WIDTH, MEM FSM state codes (IDLE, REQ, WAIT_R, DONE, DRAIN), exception cause codes,
//   load-mask encodings.
//  Sub-module load_align (combinational): rdata, addr[1:0], l_mask -> extended XLEN value. FSM, counter, muxes in top.
// TESTING
//  lb addr 0x103, rdata 0x80FF_0000, gnt at 0, rvalid +2 -> wb 0xFFFFFF80, stall high 3 cycles, RF write in DONE.
//  sh addr 0x202, byte_we 1100, gnt delayed 4 cycles -> req held 4 cycles with stable addr/be; DONE next; no RF write.
//  lw addr 0x101 -> no dbus_req, mem_exp_flag=1, cause 4, mem_req_rf_o=0, no stall.
//  Load gnt then pipe_flush in WAIT_R, next lw arrives; rvalid 3 cycles later -> data dropped;
//   new lw is issued only after DRAIN exits.
//  Load gnt never asserted -> after 255 cycles mem_exp_flag=1, cause 5, req dropped, stall released.
//  add (no mem) back-to-back after lbu 0xAB -> wb 0x000000AB, then alu_res passthrough, mem_fw_valid each cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// State codes, exception causes and load-mask encodings.
package mem_stage_pkg;

   localparam int XLEN = 32;
   localparam int RF_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_R,
      S_DONE,
      S_DRAIN
   } mem_state_e;

   localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
   localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

   localparam logic [3:0] LM_BYTE = 4'b0001;
   localparam logic [3:0] LM_HALF = 4'b0011;
   localparam logic [3:0] LM_WORD = 4'b1111;

   // The size field of the mask is used for stores as well as loads.
   function automatic logic misaligned(
      input logic [3:0] sz,
      input logic [1:0] lo
   );
      return ((sz == LM_HALF) && lo[0]) ||
             ((sz == LM_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the
// bus word and zero- or sign-extends it.
module mem_stage_load_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [4:0]      l_mask,
   output logic [XLEN-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = 8'(rdata >> {addr_lo, 3'b000});
      h = 16'(rdata >> {addr_lo[1], 4'b0000});
      data = rdata;
      unique case (1'b1)
         (l_mask[3:0] == LM_BYTE):
            data = l_mask[4] ? {{(XLEN-8){b[7]}}, b}
                             : {{(XLEN-8){1'b0}}, b};
         (l_mask[3:0] == LM_HALF):
            data = l_mask[4] ? {{(XLEN-16){h[15]}}, h}
                             : {{(XLEN-16){1'b0}}, h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/gnt/rvalid data-bus handshake, load
// alignment, writeback/bypass muxing, stall and bus exceptions.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN        = mem_stage_pkg::XLEN,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_flush,
   input  logic            mem_valid,
   input  logic            mem_re,
   input  logic            mem_we,
   input  logic [XLEN-1:0] mem_ls_addr,
   input  logic [4:0]      mem_l_mask,
   input  logic [3:0]      mem_byte_we,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_alu_res,
   input  logic            mem_req_rf_i,
   input  logic [4:0]      mem_rf_waddr_i,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [3:0]      dbus_be,
   output logic [XLEN-1:0] dbus_wdata,
   input  logic            dbus_gnt,
   input  logic            dbus_rvalid,
   input  logic [XLEN-1:0] dbus_rdata,
   output logic            mem_stall,
   output logic            mem_req_rf_o,
   output logic [4:0]      mem_rf_waddr_o,
   output logic [XLEN-1:0] mem_wb_data,
   output logic            mem_fw_valid,
   output logic            mem_exp_flag,
   output logic [3:0]      mem_exp_cause
);

   mem_state_e      state_q, state_d;
   logic [7:0]      cnt_q;
   logic [XLEN-1:0] load_data_q;
   logic [XLEN-1:0] align_data;
   logic            to_err_q;
   logic            to_hit;
   logic            is_mem;
   logic            mis;
   logic            start;
   logic            tmo;

   assign is_mem = mem_valid & (mem_re | mem_we);
   assign mis    = misaligned(mem_l_mask[3:0], mem_ls_addr[1:0]);
   assign start  = is_mem & ~mis & ~pipe_flush;
   assign tmo    = (cnt_q == 8'(TIMEOUT_CYC - 1));
   assign mem_rf_waddr_o = mem_rf_waddr_i;

   mem_stage_load_align #(.XLEN(XLEN)) u_align (
      .rdata   (dbus_rdata),
      .addr_lo (mem_ls_addr[1:0]),
      .l_mask  (mem_l_mask),
      .data    (align_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      to_hit  = 1'b0;
      unique case (state_q)
         S_IDLE:
            if (start) state_d = S_REQ;
         S_REQ:
            // A granted read is still owed an rvalid even if flushed.
            if (pipe_flush)
               state_d = (dbus_gnt & ~dbus_we) ? S_DRAIN : S_IDLE;
            else if (dbus_gnt)
               state_d = dbus_we ? S_DONE : S_WAIT_R;
            else if (tmo) begin
               state_d = S_DONE;
               to_hit  = 1'b1;
            end
         S_WAIT_R:
            if (pipe_flush)
               state_d = (dbus_rvalid | tmo) ? S_IDLE : S_DRAIN;
            else if (dbus_rvalid)
               state_d = S_DONE;
            else if (tmo) begin
               state_d = S_DONE;
               to_hit  = 1'b1;
            end
         S_DONE:
            state_d = S_IDLE;
         S_DRAIN:
            if (dbus_rvalid | tmo) state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         to_err_q    <= 1'b0;
         load_data_q <= '0;
         dbus_req    <= 1'b0;
         dbus_we     <= 1'b0;
         dbus_addr   <= '0;
         dbus_be     <= '0;
         dbus_wdata  <= '0;
      end else begin
         if (state_d != state_q || state_q == S_IDLE)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 8'd1;
         to_err_q <= to_hit;
         if (state_q == S_IDLE && start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_we;
            dbus_addr  <= {mem_ls_addr[XLEN-1:2], 2'b00};
            dbus_be    <= mem_we ? mem_byte_we
                         : 4'(mem_l_mask[3:0] << mem_ls_addr[1:0]);
            dbus_wdata <= mem_wdata;
         end else if (state_q == S_REQ && state_d != S_REQ) begin
            dbus_req <= 1'b0;
         end
         if (state_q == S_WAIT_R && dbus_rvalid && !pipe_flush)
            load_data_q <= align_data;
      end
   end

   always_comb begin
      mem_stall     = 1'b0;
      mem_req_rf_o  = 1'b0;
      mem_fw_valid  = 1'b0;
      mem_exp_flag  = 1'b0;
      mem_exp_cause = 4'd0;
      mem_wb_data   = mem_alu_res;
      unique case (state_q)
         S_IDLE, S_DRAIN: begin
            if (is_mem) begin
               if (state_q == S_DRAIN) begin
                  mem_stall = 1'b1;
               end else if (mis) begin
                  mem_exp_flag  = ~pipe_flush;
                  mem_exp_cause = mem_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
               end else begin
                  mem_stall = start;
               end
            end else begin
               mem_req_rf_o = mem_valid & mem_req_rf_i & ~pipe_flush;
               mem_fw_valid = mem_valid & mem_req_rf_i;
            end
         end
         S_REQ, S_WAIT_R:
            mem_stall = 1'b1;
         S_DONE: begin
            mem_exp_flag = to_err_q & ~pipe_flush;
            if (to_err_q)
               mem_exp_cause = dbus_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            if (!dbus_we) mem_wb_data = load_data_q;
            mem_req_rf_o = mem_valid & mem_req_rf_i &
                           ~pipe_flush & ~to_err_q;
            mem_fw_valid = mem_req_rf_o;
         end
         default: mem_stall = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalign,
// flush/drain, bus timeout and ALU pass-through.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_flush, mem_valid, mem_re, mem_we;
   logic [31:0] mem_ls_addr, mem_wdata, mem_alu_res;
   logic [4:0]  mem_l_mask, mem_rf_waddr_i, mem_rf_waddr_o;
   logic [3:0]  mem_byte_we, dbus_be, mem_exp_cause;
   logic        mem_req_rf_i;
   logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, mem_wb_data;
   logic        mem_stall, mem_req_rf_o, mem_fw_valid, mem_exp_flag;

   int checks = 0;
   int failures = 0;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
      .mem_valid(mem_valid), .mem_re(mem_re), .mem_we(mem_we),
      .mem_ls_addr(mem_ls_addr), .mem_l_mask(mem_l_mask),
      .mem_byte_we(mem_byte_we), .mem_wdata(mem_wdata),
      .mem_alu_res(mem_alu_res), .mem_req_rf_i(mem_req_rf_i),
      .mem_rf_waddr_i(mem_rf_waddr_i), .dbus_req(dbus_req),
      .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .mem_stall(mem_stall), .mem_req_rf_o(mem_req_rf_o),
      .mem_rf_waddr_o(mem_rf_waddr_o), .mem_wb_data(mem_wb_data),
      .mem_fw_valid(mem_fw_valid), .mem_exp_flag(mem_exp_flag),
      .mem_exp_cause(mem_exp_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr();
      pipe_flush = 0; mem_valid = 0; mem_re = 0; mem_we = 0;
      mem_ls_addr = 0; mem_l_mask = 0; mem_byte_we = 0;
      mem_wdata = 0; mem_alu_res = 0; mem_req_rf_i = 0;
      mem_rf_waddr_i = 0; dbus_gnt = 0; dbus_rvalid = 0;
      dbus_rdata = 0;
   endtask

   task automatic set_ld(input logic [31:0] a, input logic [4:0] m);
      clr();
      mem_valid = 1; mem_re = 1; mem_ls_addr = a; mem_l_mask = m;
      mem_req_rf_i = 1; mem_rf_waddr_i = 5'd7;
      mem_alu_res = 32'hDEAD_0000;
   endtask

   // gnt in the first REQ cycle, rvalid in the next one
   task automatic do_load(input string t, input logic [31:0] a,
                          input logic [4:0] m, input logic [31:0] rd,
                          input logic [31:0] exp, input logic [3:0] be);
      set_ld(a, m);
      smp(); chk({t, "_c0_stall"}, mem_stall, 1);
      chk({t, "_c0_rf"}, mem_req_rf_o, 0);
      nxt(); dbus_gnt = 1;
      smp(); chk({t, "_req"}, dbus_req, 1);
      chk({t, "_addr"}, dbus_addr, {a[31:2], 2'b00});
      chk({t, "_be"}, dbus_be, be);
      chk({t, "_c1_stall"}, mem_stall, 1);
      nxt(); dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = rd;
      smp(); chk({t, "_c2_stall"}, mem_stall, 1);
      chk({t, "_c2_req"}, dbus_req, 0);
      nxt(); dbus_rvalid = 0; dbus_rdata = 0;
      smp(); chk({t, "_wb"}, mem_wb_data, exp);
      chk({t, "_done_stall"}, mem_stall, 0);
      chk({t, "_rf"}, mem_req_rf_o, 1);
      chk({t, "_fw"}, mem_fw_valid, 1);
      chk({t, "_waddr"}, mem_rf_waddr_o, 7);
   endtask

   initial begin
      int n;
      int reqc;
      clr();
      repeat (2) @(posedge clk);
      #1;
      smp();
      chk("rst_req", dbus_req, 0);
      chk("rst_we", dbus_we, 0);
      chk("rst_addr", dbus_addr, 0);
      chk("rst_be", dbus_be, 0);
      chk("rst_wdata", dbus_wdata, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_rf", mem_req_rf_o, 0);
      chk("rst_fw", mem_fw_valid, 0);
      chk("rst_exp", mem_exp_flag, 0);
      nxt(); rst_n = 1;
      nxt();

      do_load("lb", 32'h103, 5'b10001, 32'h80FF_0000,
              32'hFFFF_FF80, 4'b1000);
      nxt();
      do_load("lh", 32'h702, 5'b10011, 32'h8001_0000,
              32'hFFFF_8001, 4'b1100);
      nxt();

      // store, gnt in the fourth request cycle
      clr();
      mem_valid = 1; mem_we = 1; mem_ls_addr = 32'h202;
      mem_l_mask = 5'b00011; mem_byte_we = 4'b1100;
      mem_wdata = 32'h1234_0000; mem_alu_res = 32'h55;
      smp(); chk("sh_c0_stall", mem_stall, 1);
      for (int i = 1; i <= 4; i++) begin
         nxt(); dbus_gnt = (i == 4);
         smp();
         chk("sh_req", dbus_req, 1);
         chk("sh_we", dbus_we, 1);
         chk("sh_addr", dbus_addr, 32'h200);
         chk("sh_be", dbus_be, 4'b1100);
         chk("sh_wdata", dbus_wdata, 32'h1234_0000);
         chk("sh_stall", mem_stall, 1);
      end
      nxt(); dbus_gnt = 0; dbus_rvalid = 1;
      smp(); chk("sh_done_stall", mem_stall, 0);
      chk("sh_done_req", dbus_req, 0);
      chk("sh_done_rf", mem_req_rf_o, 0);
      chk("sh_done_exp", mem_exp_flag, 0);
      nxt();

      // misaligned load and store
      set_ld(32'h101, 5'b01111);
      smp(); chk("lwmis_exp", mem_exp_flag, 1);
      chk("lwmis_cause", mem_exp_cause, 4);
      chk("lwmis_rf", mem_req_rf_o, 0);
      chk("lwmis_stall", mem_stall, 0);
      nxt(); clr();
      smp(); chk("lwmis_noreq", dbus_req, 0);
      nxt();
      clr(); mem_valid = 1; mem_we = 1; mem_ls_addr = 32'h201;
      mem_l_mask = 5'b00011; mem_byte_we = 4'b0110;
      smp(); chk("shmis_exp", mem_exp_flag, 1);
      chk("shmis_cause", mem_exp_cause, 6);
      chk("shmis_stall", mem_stall, 0);
      nxt(); clr();
      smp(); chk("shmis_noreq", dbus_req, 0);
      nxt();

      // flush in WAIT_R, next load waits for DRAIN to finish
      set_ld(32'h300, 5'b01111);
      smp();
      nxt(); dbus_gnt = 1;
      smp();
      nxt(); dbus_gnt = 0; pipe_flush = 1;
      smp(); chk("fl_rf", mem_req_rf_o, 0);
      nxt(); set_ld(32'h400, 5'b01111);
      smp(); chk("dr_stall0", mem_stall, 1);
      chk("dr_req0", dbus_req, 0);
      nxt();
      smp(); chk("dr_stall1", mem_stall, 1);
      chk("dr_req1", dbus_req, 0);
      nxt(); dbus_rvalid = 1; dbus_rdata = 32'hBAD0_BAD0;
      smp(); chk("dr_stall2", mem_stall, 1);
      chk("dr_rf2", mem_req_rf_o, 0);
      nxt(); dbus_rvalid = 0; dbus_rdata = 0;
      smp(); chk("dr_idle_stall", mem_stall, 1);
      chk("dr_idle_req", dbus_req, 0);
      nxt(); dbus_gnt = 1;
      smp(); chk("dr_new_req", dbus_req, 1);
      chk("dr_new_addr", dbus_addr, 32'h400);
      nxt(); dbus_gnt = 0; dbus_rvalid = 1;
      dbus_rdata = 32'h1122_3344;
      smp();
      nxt(); dbus_rvalid = 0; dbus_rdata = 0;
      smp(); chk("dr_new_wb", mem_wb_data, 32'h1122_3344);
      chk("dr_new_rf", mem_req_rf_o, 1);
      nxt();

      // bus never grants: timeout after 255 request cycles
      set_ld(32'h500, 5'b01111);
      smp(); chk("to_c0_stall", mem_stall, 1);
      n = 0; reqc = 0;
      while (n < 400) begin
         nxt(); smp(); n++;
         if (!mem_stall) break;
         if (dbus_req) reqc++;
      end
      chk("to_stall", mem_stall, 0);
      chk("to_reqcyc", reqc, 255);
      chk("to_exp", mem_exp_flag, 1);
      chk("to_cause", mem_exp_cause, 5);
      chk("to_req", dbus_req, 0);
      chk("to_rf", mem_req_rf_o, 0);
      nxt();

      // lbu followed by back-to-back ALU ops
      do_load("lbu", 32'h601, 5'b00001, 32'h0000_AB00,
              32'h0000_00AB, 4'b0010);
      nxt(); clr();
      mem_valid = 1; mem_req_rf_i = 1; mem_alu_res = 32'h1234;
      smp(); chk("add1_wb", mem_wb_data, 32'h1234);
      chk("add1_fw", mem_fw_valid, 1);
      chk("add1_rf", mem_req_rf_o, 1);
      chk("add1_stall", mem_stall, 0);
      nxt(); mem_alu_res = 32'h5678;
      smp(); chk("add2_wb", mem_wb_data, 32'h5678);
      chk("add2_fw", mem_fw_valid, 1);
      chk("add2_stall", mem_stall, 0);
      nxt(); clr();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
